// File: rtl/arbitro_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM states,
// read-owner codes and default bus widths.
package arbitro_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;
  localparam int LONG_W_DEF = 4;

  typedef enum logic [1:0] {
    REPOSO     = 2'd0,
    RAFAGA     = 2'd1,
    RANURA_CPU = 2'd2
  } estado_t;

  localparam logic DUENO_CPU = 1'b0;
  localparam logic DUENO_DMA = 1'b1;

endpackage

// File: rtl/contador_rafaga.sv
// Burst bookkeeping: latched base/length, beat counter, wrapping beat
// address and last-beat flag.
module contador_rafaga
  import arbitro_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LONG_W = LONG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cargar,
  input  logic              avanzar,
  input  logic [ADDR_W-1:0] base,
  input  logic [LONG_W-1:0] long,
  output logic [ADDR_W-1:0] direc,
  output logic              ultimo
);

  logic [ADDR_W-1:0] base_q;
  logic [LONG_W-1:0] long_q;
  logic [LONG_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      long_q <= '0;
      cnt_q  <= '0;
    end else if (cargar) begin
      base_q <= base;
      long_q <= long;
      cnt_q  <= '0;
    end else if (avanzar) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Sum truncates to ADDR_W, so the address wraps modulo 2^ADDR_W.
  assign direc  = base_q + ADDR_W'(cnt_q);
  assign ultimo = (cnt_q == long_q);

endmodule

// File: rtl/arbitro_memoria_datos.sv
// Single-port data memory arbiter between CPU and a burst DMA requester.
// Optional macro ARB_INTERCALADO_EN inserts a CPU slot between burst beats.
module arbitro_memoria_datos
  import arbitro_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LONG_W = LONG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_EscrMem,
  input  logic              cpu_LeerMem,
  input  logic [ADDR_W-1:0] cpu_Direc,
  input  logic [DATA_W-1:0] cpu_Datain,
  output logic              cpu_espera,
  output logic              cpu_listo,
  output logic [DATA_W-1:0] cpu_Dataout,
  input  logic              dma_req,
  input  logic              dma_escr,
  input  logic [ADDR_W-1:0] dma_dir_base,
  input  logic [LONG_W-1:0] dma_long,
  input  logic [DATA_W-1:0] dma_Datain,
  output logic              dma_gnt,
  output logic              dma_listo,
  output logic [DATA_W-1:0] dma_Dataout,
  output logic              dma_fin,
  output logic              mem_EscrMem,
  output logic              mem_LeerMem,
  output logic [ADDR_W-1:0] mem_Direc,
  output logic [DATA_W-1:0] mem_Datain,
  input  logic [DATA_W-1:0] mem_Dataout
);

  estado_t           estado_q, estado_d;
  logic              escr_q;
  logic              pend_q;
  logic              dueno_q;
  logic [DATA_W-1:0] cpu_dato_q;
  logic [DATA_W-1:0] dma_dato_q;

  logic              cpu_req;
  logic              servir_cpu;
  logic              cargar;
  logic              avanzar;
  logic              lee_cpu;
  logic              lee_dma;
  logic [ADDR_W-1:0] dir_rafaga;
  logic              ultimo;

  assign cpu_req = cpu_EscrMem | cpu_LeerMem;

  contador_rafaga #(
    .ADDR_W(ADDR_W),
    .LONG_W(LONG_W)
  ) u_contador (
    .clk    (clk),
    .reset  (reset),
    .cargar (cargar),
    .avanzar(avanzar),
    .base   (dma_dir_base),
    .long   (dma_long),
    .direc  (dir_rafaga),
    .ultimo (ultimo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= REPOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Everything is gated by reset so outputs read zero while it is held.
  always_comb begin
    estado_d    = estado_q;
    servir_cpu  = 1'b0;
    cargar      = 1'b0;
    avanzar     = 1'b0;
    lee_cpu     = 1'b0;
    lee_dma     = 1'b0;
    cpu_espera  = 1'b0;
    dma_gnt     = 1'b0;
    dma_fin     = 1'b0;
    mem_EscrMem = 1'b0;
    mem_LeerMem = 1'b0;
    mem_Direc   = '0;
    mem_Datain  = '0;
    if (!reset) begin
      case (estado_q)
        REPOSO: begin
          if (cpu_req) begin
            servir_cpu = 1'b1;
          end else if (dma_req) begin
            cargar   = 1'b1;
            estado_d = RAFAGA;
          end
        end
        RAFAGA: begin
          dma_gnt     = 1'b1;
          avanzar     = 1'b1;
          cpu_espera  = cpu_req;
          mem_EscrMem = escr_q;
          mem_LeerMem = ~escr_q;
          lee_dma     = ~escr_q;
          mem_Direc   = dir_rafaga;
          mem_Datain  = escr_q ? dma_Datain : '0;
          if (ultimo) begin
            dma_fin  = 1'b1;
            estado_d = REPOSO;
          end
`ifdef ARB_INTERCALADO_EN
          else if (cpu_req) begin
            estado_d = RANURA_CPU;
          end
`endif
        end
`ifdef ARB_INTERCALADO_EN
        RANURA_CPU: begin
          servir_cpu = 1'b1;
          estado_d   = RAFAGA;
        end
`endif
        default: estado_d = REPOSO;
      endcase

      // A simultaneous write and read from the CPU issues only the write.
      if (servir_cpu && cpu_req) begin
        mem_EscrMem = cpu_EscrMem;
        mem_LeerMem = cpu_LeerMem & ~cpu_EscrMem;
        lee_cpu     = cpu_LeerMem & ~cpu_EscrMem;
        mem_Direc   = cpu_Direc;
        mem_Datain  = cpu_Datain;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      escr_q     <= 1'b0;
      pend_q     <= 1'b0;
      dueno_q    <= DUENO_CPU;
      cpu_dato_q <= '0;
      dma_dato_q <= '0;
    end else begin
      if (cargar) begin
        escr_q <= dma_escr;
      end
      pend_q  <= lee_cpu | lee_dma;
      dueno_q <= lee_dma ? DUENO_DMA : DUENO_CPU;
      if (cpu_listo) begin
        cpu_dato_q <= mem_Dataout;
      end
      if (dma_listo) begin
        dma_dato_q <= mem_Dataout;
      end
    end
  end

  assign cpu_listo   = ~reset & pend_q & (dueno_q == DUENO_CPU);
  assign dma_listo   = ~reset & pend_q & (dueno_q == DUENO_DMA);
  assign cpu_Dataout = reset ? '0 : (cpu_listo ? mem_Dataout : cpu_dato_q);
  assign dma_Dataout = reset ? '0 : (dma_listo ? mem_Dataout : dma_dato_q);

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Directed self-checking bench for arbitro_memoria_datos with a behavioural
// single-port memory; expectations follow ARB_INTERCALADO_EN when defined.
module tb_arbitro_memoria_datos;

  logic        clk;
  logic        reset;
  logic        cpu_EscrMem, cpu_LeerMem;
  logic [7:0]  cpu_Direc;
  logic [31:0] cpu_Datain;
  logic        cpu_espera, cpu_listo;
  logic [31:0] cpu_Dataout;
  logic        dma_req, dma_escr;
  logic [7:0]  dma_dir_base;
  logic [3:0]  dma_long;
  logic [31:0] dma_Datain;
  logic        dma_gnt, dma_listo, dma_fin;
  logic [31:0] dma_Dataout;
  logic        mem_EscrMem, mem_LeerMem;
  logic [7:0]  mem_Direc;
  logic [31:0] mem_Datain;
  logic [31:0] mem_Dataout;

  logic [31:0] mem [256];
  logic [31:0] rd;
  logic [7:0]  dir_esp [4];

  int n_chk;
  int n_fail;

  arbitro_memoria_datos dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_EscrMem (cpu_EscrMem),
    .cpu_LeerMem (cpu_LeerMem),
    .cpu_Direc   (cpu_Direc),
    .cpu_Datain  (cpu_Datain),
    .cpu_espera  (cpu_espera),
    .cpu_listo   (cpu_listo),
    .cpu_Dataout (cpu_Dataout),
    .dma_req     (dma_req),
    .dma_escr    (dma_escr),
    .dma_dir_base(dma_dir_base),
    .dma_long    (dma_long),
    .dma_Datain  (dma_Datain),
    .dma_gnt     (dma_gnt),
    .dma_listo   (dma_listo),
    .dma_Dataout (dma_Dataout),
    .dma_fin     (dma_fin),
    .mem_EscrMem (mem_EscrMem),
    .mem_LeerMem (mem_LeerMem),
    .mem_Direc   (mem_Direc),
    .mem_Datain  (mem_Datain),
    .mem_Dataout (mem_Dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_EscrMem) mem[mem_Direc] <= mem_Datain;
    if (mem_LeerMem) rd <= mem[mem_Direc];
  end
  assign mem_Dataout = rd;

  task automatic fin_ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic inputs_idle();
    cpu_EscrMem = 0; cpu_LeerMem = 0; cpu_Direc = 0; cpu_Datain = 0;
    dma_req = 0; dma_escr = 0; dma_dir_base = 0; dma_long = 0; dma_Datain = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    cpu_EscrMem = 1; cpu_LeerMem = 1; cpu_Direc = 8'h55; cpu_Datain = 32'h1234_5678;
    dma_req = 1; dma_escr = 1; dma_dir_base = 8'h10; dma_long = 4'h3; dma_Datain = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_chk++; if ({mem_EscrMem, mem_LeerMem, mem_Direc, mem_Datain} !== 42'd0) begin n_fail++; $display("FAIL reset_mem cyc %0d: got %h required 0", c, {mem_EscrMem, mem_LeerMem, mem_Direc, mem_Datain}); end
      n_chk++; if ({cpu_espera, cpu_listo, cpu_Dataout, dma_gnt, dma_listo, dma_Dataout, dma_fin} !== 69'd0) begin n_fail++; $display("FAIL reset_out cyc %0d: got %h required 0", c, {cpu_espera, cpu_listo, cpu_Dataout, dma_gnt, dma_listo, dma_Dataout, dma_fin}); end
      fin_ciclo();
    end
    reset = 0;
    inputs_idle();
  endtask

  task automatic test_cpu();
    cpu_EscrMem = 1; cpu_Direc = 8'h10; cpu_Datain = 32'hDEAD_BEEF;
    @(negedge clk);
    n_chk++; if (mem_EscrMem !== 1'b1) begin n_fail++; $display("FAIL cpu_wr_en: got %b required 1", mem_EscrMem); end
    n_chk++; if (mem_Direc !== 8'h10) begin n_fail++; $display("FAIL cpu_wr_dir: got %h required 10", mem_Direc); end
    n_chk++; if (mem_Datain !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cpu_wr_dato: got %h required deadbeef", mem_Datain); end
    n_chk++; if (cpu_espera !== 1'b0) begin n_fail++; $display("FAIL cpu_wr_espera: got %b required 0", cpu_espera); end
    fin_ciclo();
    cpu_EscrMem = 0; cpu_LeerMem = 1;
    @(negedge clk);
    n_chk++; if ({mem_EscrMem, mem_LeerMem} !== 2'b01) begin n_fail++; $display("FAIL cpu_rd_en: got %b required 01", {mem_EscrMem, mem_LeerMem}); end
    fin_ciclo();
    cpu_LeerMem = 0;
    @(negedge clk);
    n_chk++; if (cpu_listo !== 1'b1) begin n_fail++; $display("FAIL cpu_rd_listo: got %b required 1", cpu_listo); end
    n_chk++; if (cpu_Dataout !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cpu_rd_dato: got %h required deadbeef", cpu_Dataout); end
    n_chk++; if (dma_listo !== 1'b0) begin n_fail++; $display("FAIL cpu_rd_dma_listo: got %b required 0", dma_listo); end
    fin_ciclo();
    cpu_EscrMem = 1; cpu_LeerMem = 1; cpu_Direc = 8'h20; cpu_Datain = 32'h0000_0055;
    @(negedge clk);
    n_chk++; if (cpu_listo !== 1'b0) begin n_fail++; $display("FAIL cpu_listo_pulse: got %b required 0", cpu_listo); end
    n_chk++; if (cpu_Dataout !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cpu_dato_hold: got %h required deadbeef", cpu_Dataout); end
    n_chk++; if ({mem_EscrMem, mem_LeerMem} !== 2'b10) begin n_fail++; $display("FAIL cpu_both_write_only: got %b required 10", {mem_EscrMem, mem_LeerMem}); end
    fin_ciclo();
    inputs_idle();
    @(negedge clk);
    n_chk++; if (cpu_listo !== 1'b0) begin n_fail++; $display("FAIL cpu_both_no_listo: got %b required 0", cpu_listo); end
    n_chk++; if ({mem_EscrMem, mem_LeerMem, mem_Direc, mem_Datain} !== 42'd0) begin n_fail++; $display("FAIL idle_mem: got %h required 0", {mem_EscrMem, mem_LeerMem, mem_Direc, mem_Datain}); end
    fin_ciclo();
  endtask

  task automatic test_dma_write();
    dma_req = 1; dma_escr = 1; dma_dir_base = 8'hFE; dma_long = 4'd3;
    @(negedge clk);
    n_chk++; if ({dma_gnt, mem_EscrMem, mem_LeerMem} !== 3'b000) begin n_fail++; $display("FAIL dw_accept_idle: got %b required 000", {dma_gnt, mem_EscrMem, mem_LeerMem}); end
    fin_ciclo();
    dma_req = 0;
    for (int i = 0; i < 4; i++) begin
      dma_Datain = 32'(i + 1);
      @(negedge clk);
      n_chk++; if ({dma_gnt, mem_EscrMem, mem_LeerMem} !== 3'b110) begin n_fail++; $display("FAIL dw_gnt beat %0d: got %b required 110", i, {dma_gnt, mem_EscrMem, mem_LeerMem}); end
      n_chk++; if (mem_Direc !== dir_esp[i]) begin n_fail++; $display("FAIL dw_dir beat %0d: got %h required %h", i, mem_Direc, dir_esp[i]); end
      n_chk++; if (mem_Datain !== 32'(i + 1)) begin n_fail++; $display("FAIL dw_dato beat %0d: got %h required %h", i, mem_Datain, i + 1); end
      n_chk++; if (dma_fin !== (i == 3)) begin n_fail++; $display("FAIL dw_fin beat %0d: got %b required %b", i, dma_fin, (i == 3)); end
      fin_ciclo();
    end
    dma_Datain = 0;
    @(negedge clk);
    n_chk++; if ({dma_gnt, dma_fin} !== 2'b00) begin n_fail++; $display("FAIL dw_end: got %b required 00", {dma_gnt, dma_fin}); end
    fin_ciclo();
    for (int i = 0; i < 4; i++) begin
      cpu_LeerMem = 1; cpu_Direc = dir_esp[i];
      @(negedge clk);
      fin_ciclo();
      cpu_LeerMem = 0;
      @(negedge clk);
      n_chk++; if ({cpu_listo, cpu_Dataout} !== {1'b1, 32'(i + 1)}) begin n_fail++; $display("FAIL dw_readback %0d: got %b/%h required 1/%h", i, cpu_listo, cpu_Dataout, i + 1); end
      fin_ciclo();
    end
  endtask

  task automatic test_dma_read();
    dma_req = 1; dma_escr = 0; dma_dir_base = 8'hFE; dma_long = 4'd3;
    @(negedge clk);
    fin_ciclo();
    dma_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++; if ({dma_gnt, mem_EscrMem, mem_LeerMem} !== 3'b101) begin n_fail++; $display("FAIL dr_gnt beat %0d: got %b required 101", i, {dma_gnt, mem_EscrMem, mem_LeerMem}); end
      n_chk++; if (mem_Direc !== dir_esp[i]) begin n_fail++; $display("FAIL dr_dir beat %0d: got %h required %h", i, mem_Direc, dir_esp[i]); end
      n_chk++; if (dma_fin !== (i == 3)) begin n_fail++; $display("FAIL dr_fin beat %0d: got %b required %b", i, dma_fin, (i == 3)); end
      n_chk++; if (dma_listo !== (i != 0)) begin n_fail++; $display("FAIL dr_listo beat %0d: got %b required %b", i, dma_listo, (i != 0)); end
      if (i != 0) begin
        n_chk++; if (dma_Dataout !== 32'(i)) begin n_fail++; $display("FAIL dr_dato beat %0d: got %h required %h", i, dma_Dataout, i); end
      end
      n_chk++; if (cpu_listo !== 1'b0) begin n_fail++; $display("FAIL dr_cpu_listo beat %0d: got %b required 0", i, cpu_listo); end
      fin_ciclo();
    end
    @(negedge clk);
    n_chk++; if ({dma_listo, dma_Dataout, dma_gnt, cpu_listo} !== {1'b1, 32'd4, 1'b0, 1'b0}) begin n_fail++; $display("FAIL dr_tail: got %b/%h/%b/%b required 1/4/0/0", dma_listo, dma_Dataout, dma_gnt, cpu_listo); end
    fin_ciclo();
    @(negedge clk);
    n_chk++; if ({dma_listo, dma_Dataout} !== {1'b0, 32'd4}) begin n_fail++; $display("FAIL dr_hold: got %b/%h required 0/4", dma_listo, dma_Dataout); end
    fin_ciclo();
  endtask

  task automatic test_intercalado();
    dma_req = 1; dma_escr = 1; dma_dir_base = 8'h40; dma_long = 4'd3;
    @(negedge clk);
    fin_ciclo();
    dma_req = 0; dma_Datain = 32'hA0;
    @(negedge clk);
    n_chk++; if ({dma_gnt, mem_Direc, cpu_espera} !== {1'b1, 8'h40, 1'b0}) begin n_fail++; $display("FAIL ic_beat1: got %b/%h/%b required 1/40/0", dma_gnt, mem_Direc, cpu_espera); end
    fin_ciclo();
    dma_Datain = 32'hA1; cpu_LeerMem = 1; cpu_Direc = 8'h10;
    @(negedge clk);
    n_chk++; if ({dma_gnt, mem_Direc, cpu_espera} !== {1'b1, 8'h41, 1'b1}) begin n_fail++; $display("FAIL ic_beat2: got %b/%h/%b required 1/41/1", dma_gnt, mem_Direc, cpu_espera); end
    fin_ciclo();
`ifdef ARB_INTERCALADO_EN
    @(negedge clk);
    n_chk++; if ({dma_gnt, cpu_espera, mem_LeerMem, mem_Direc} !== {1'b0, 1'b0, 1'b1, 8'h10}) begin n_fail++; $display("FAIL ic_slot: got %b/%b/%b/%h required 0/0/1/10", dma_gnt, cpu_espera, mem_LeerMem, mem_Direc); end
    fin_ciclo();
    cpu_LeerMem = 0; dma_Datain = 32'hA2;
    @(negedge clk);
    n_chk++; if ({dma_gnt, mem_Direc} !== {1'b1, 8'h42}) begin n_fail++; $display("FAIL ic_beat3: got %b/%h required 1/42", dma_gnt, mem_Direc); end
    n_chk++; if ({cpu_listo, cpu_Dataout} !== {1'b1, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL ic_cpu_dato: got %b/%h required 1/deadbeef", cpu_listo, cpu_Dataout); end
    fin_ciclo();
    dma_Datain = 32'hA3;
    @(negedge clk);
    n_chk++; if ({dma_gnt, mem_Direc, dma_fin} !== {1'b1, 8'h43, 1'b1}) begin n_fail++; $display("FAIL ic_beat4: got %b/%h/%b required 1/43/1", dma_gnt, mem_Direc, dma_fin); end
    fin_ciclo();
    dma_Datain = 0;
    @(negedge clk);
    n_chk++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL ic_end: got %b required 0", dma_gnt); end
    fin_ciclo();
`else
    dma_Datain = 32'hA2;
    @(negedge clk);
    n_chk++; if ({dma_gnt, mem_Direc, cpu_espera} !== {1'b1, 8'h42, 1'b1}) begin n_fail++; $display("FAIL ic_beat3: got %b/%h/%b required 1/42/1", dma_gnt, mem_Direc, cpu_espera); end
    fin_ciclo();
    dma_Datain = 32'hA3;
    @(negedge clk);
    n_chk++; if ({dma_gnt, mem_Direc, cpu_espera, dma_fin} !== {1'b1, 8'h43, 1'b1, 1'b1}) begin n_fail++; $display("FAIL ic_beat4: got %b/%h/%b/%b required 1/43/1/1", dma_gnt, mem_Direc, cpu_espera, dma_fin); end
    fin_ciclo();
    dma_Datain = 0;
    @(negedge clk);
    n_chk++; if ({dma_gnt, cpu_espera, mem_LeerMem, mem_Direc} !== {1'b0, 1'b0, 1'b1, 8'h10}) begin n_fail++; $display("FAIL ic_served: got %b/%b/%b/%h required 0/0/1/10", dma_gnt, cpu_espera, mem_LeerMem, mem_Direc); end
    fin_ciclo();
    cpu_LeerMem = 0;
    @(negedge clk);
    n_chk++; if ({cpu_listo, cpu_Dataout} !== {1'b1, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL ic_cpu_dato: got %b/%h required 1/deadbeef", cpu_listo, cpu_Dataout); end
    fin_ciclo();
`endif
    n_chk++; if (mem[8'h42] !== 32'hA2) begin n_fail++; $display("FAIL ic_mem42: got %h required a2", mem[8'h42]); end
    n_chk++; if (mem[8'h43] !== 32'hA3) begin n_fail++; $display("FAIL ic_mem43: got %h required a3", mem[8'h43]); end
  endtask

  task automatic test_back_to_back();
    dma_req = 1; dma_escr = 0; dma_dir_base = 8'hFE; dma_long = 4'd0;
    cpu_EscrMem = 1; cpu_Direc = 8'h30; cpu_Datain = 32'h1234;
    @(negedge clk);
    n_chk++; if ({mem_EscrMem, mem_Direc, dma_gnt, cpu_espera} !== {1'b1, 8'h30, 1'b0, 1'b0}) begin n_fail++; $display("FAIL bb_cpu_first: got %b/%h/%b/%b required 1/30/0/0", mem_EscrMem, mem_Direc, dma_gnt, cpu_espera); end
    fin_ciclo();
    cpu_EscrMem = 0;
    @(negedge clk);
    n_chk++; if ({mem_EscrMem, mem_LeerMem, dma_gnt} !== 3'b000) begin n_fail++; $display("FAIL bb_accept: got %b required 000", {mem_EscrMem, mem_LeerMem, dma_gnt}); end
    fin_ciclo();
    @(negedge clk);
    n_chk++; if ({dma_gnt, dma_fin, mem_LeerMem, mem_Direc} !== {1'b1, 1'b1, 1'b1, 8'hFE}) begin n_fail++; $display("FAIL bb_beat: got %b/%b/%b/%h required 1/1/1/fe", dma_gnt, dma_fin, mem_LeerMem, mem_Direc); end
    fin_ciclo();
    cpu_LeerMem = 1; cpu_Direc = 8'h30;
    @(negedge clk);
    n_chk++; if ({dma_gnt, cpu_espera, mem_LeerMem, mem_Direc} !== {1'b0, 1'b0, 1'b1, 8'h30}) begin n_fail++; $display("FAIL bb_cpu_wins: got %b/%b/%b/%h required 0/0/1/30", dma_gnt, cpu_espera, mem_LeerMem, mem_Direc); end
    n_chk++; if ({dma_listo, dma_Dataout} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL bb_dma_dato: got %b/%h required 1/1", dma_listo, dma_Dataout); end
    fin_ciclo();
    cpu_LeerMem = 0;
    @(negedge clk);
    n_chk++; if ({cpu_listo, cpu_Dataout} !== {1'b1, 32'h1234}) begin n_fail++; $display("FAIL bb_cpu_dato: got %b/%h required 1/1234", cpu_listo, cpu_Dataout); end
    n_chk++; if ({dma_gnt, mem_LeerMem} !== 2'b00) begin n_fail++; $display("FAIL bb_accept2: got %b required 00", {dma_gnt, mem_LeerMem}); end
    fin_ciclo();
    dma_req = 0;
    @(negedge clk);
    n_chk++; if ({dma_gnt, dma_fin, mem_Direc} !== {1'b1, 1'b1, 8'hFE}) begin n_fail++; $display("FAIL bb_beat2: got %b/%b/%h required 1/1/fe", dma_gnt, dma_fin, mem_Direc); end
    fin_ciclo();
    @(negedge clk);
    n_chk++; if ({dma_listo, dma_gnt} !== 2'b10) begin n_fail++; $display("FAIL bb_tail: got %b required 10", {dma_listo, dma_gnt}); end
    fin_ciclo();
  endtask

  task automatic test_reset_burst();
    dma_req = 1; dma_escr = 0; dma_dir_base = 8'hFE; dma_long = 4'd3;
    @(negedge clk);
    fin_ciclo();
    dma_req = 0;
    @(negedge clk);
    n_chk++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL rb_beat1: got %b required 1", dma_gnt); end
    fin_ciclo();
    reset = 1;
    @(negedge clk);
    n_chk++; if ({dma_gnt, dma_fin, dma_listo, mem_LeerMem} !== 4'b0000) begin n_fail++; $display("FAIL rb_in_reset: got %b required 0000", {dma_gnt, dma_fin, dma_listo, mem_LeerMem}); end
    fin_ciclo();
    reset = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_chk++; if ({dma_gnt, dma_fin, dma_listo, dma_Dataout} !== 35'd0) begin n_fail++; $display("FAIL rb_after cyc %0d: got %b/%b/%b/%h required 0/0/0/0", c, dma_gnt, dma_fin, dma_listo, dma_Dataout); end
      fin_ciclo();
    end
    cpu_LeerMem = 1; cpu_Direc = 8'h10;
    @(negedge clk);
    n_chk++; if ({mem_LeerMem, cpu_espera} !== 2'b10) begin n_fail++; $display("FAIL rb_reposo: got %b required 10", {mem_LeerMem, cpu_espera}); end
    fin_ciclo();
    cpu_LeerMem = 0;
    @(negedge clk);
    n_chk++; if ({cpu_listo, cpu_Dataout} !== {1'b1, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL rb_cpu_dato: got %b/%h required 1/deadbeef", cpu_listo, cpu_Dataout); end
    fin_ciclo();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    dir_esp[0] = 8'hFE; dir_esp[1] = 8'hFF; dir_esp[2] = 8'h00; dir_esp[3] = 8'h01;
    test_reset();
    test_cpu();
    test_dma_write();
    test_dma_read();
    test_intercalado();
    test_back_to_back();
    test_reset_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
